// File: rtl/cell_stim_checker.sv
// cell_stim_checker: Wishbone-configured stimulus sweeper and truth-table checker for cell channels
module cell_stim_checker #(
    parameter int          NCH       = 11,
    parameter logic [31:0] ADDR_BASE = 32'h3000_0000
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_ni,
    input  logic               wbs_stb_i,
    input  logic               wbs_cyc_i,
    input  logic               wbs_we_i,
    input  logic [3:0]         wbs_sel_i,
    input  logic [31:0]        wbs_adr_i,
    input  logic [31:0]        wbs_dat_i,
    output logic               wbs_ack_o,
    output logic [31:0]        wbs_dat_o,
    output logic [3*NCH-1:0]   stim_o,
    input  logic [NCH-1:0]     resp_i,
    output logic               done_o
);
    typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, SAMPLE, FINISH} state_t;
    state_t           state_q, state_d;
    logic [2:0]       v_q, v_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [3*NCH-1:0] stim_q, stim_d;
    logic [3:0]       chan_q, chan_d;
    logic [1:0]       nin_q, nin_d;
    logic [7:0]       exp_q, exp_d;
    logic [7:0]       settle_q, settle_d;
    logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d, bad_q, bad_d;
    logic [7:0]       fail_q, fail_d;
    logic [15:0]      run_q, run_d;
    logic             ack_q, ack_d;
    logic [31:0]      dat_q, dat_d;
    logic             hit, acc, wr_ctrl, wr_settle, start, cfg_bad;
    logic [31:0]      rdata;
    logic [2:0]       last_v;
    logic [7:0]       settle_eff;
    logic             unused;
    assign unused     = &{1'b0, wbs_sel_i, wbs_adr_i[1:0]};
    assign hit        = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:4] == ADDR_BASE[31:4]);
    // a held strobe is acked at most every other cycle
    assign acc        = hit & ~ack_q;
    assign wr_ctrl    = acc & wbs_we_i & (wbs_adr_i[3:2] == 2'd0) & ~busy_q;
    assign wr_settle  = acc & wbs_we_i & (wbs_adr_i[3:2] == 2'd2) & ~busy_q;
    assign start      = wr_ctrl & wbs_dat_i[0];
    assign cfg_bad    = (32'(wbs_dat_i[7:4]) >= NCH) | (wbs_dat_i[9:8] == 2'd3);
    assign last_v     = {nin_q[1], |nin_q, 1'b1};
    assign settle_eff = (settle_q == 8'd0) ? 8'd1 : settle_q;
    assign rdata      = (wbs_adr_i[3:2] == 2'd0) ? {8'd0, exp_q, 6'd0, nin_q, chan_q, 4'd0} :
                        (wbs_adr_i[3:2] == 2'd1) ? {16'd0, fail_q, 4'd0, bad_q, pass_q, done_q, busy_q} :
                        (wbs_adr_i[3:2] == 2'd2) ? {24'd0, settle_q} : {16'd0, run_q};
    assign wbs_ack_o  = ack_q;
    assign wbs_dat_o  = dat_q;
    assign stim_o     = stim_q;
    assign done_o     = done_q;
    // bus decode, configuration writes and sweep sequencing
    always_comb begin
        state_d  = state_q;
        v_d      = v_q;
        cnt_d    = cnt_q;
        stim_d   = stim_q;
        chan_d   = chan_q;
        nin_d    = nin_q;
        exp_d    = exp_q;
        settle_d = settle_q;
        busy_d   = busy_q;
        done_d   = done_q;
        pass_d   = pass_q;
        bad_d    = bad_q;
        fail_d   = fail_q;
        run_d    = run_q;
        ack_d    = acc;
        dat_d    = (acc & ~wbs_we_i) ? rdata : 32'd0;
        if (wr_ctrl) begin
            chan_d = wbs_dat_i[7:4];
            nin_d  = wbs_dat_i[9:8];
            exp_d  = wbs_dat_i[23:16];
        end
        if (wr_settle) settle_d = wbs_dat_i[7:0];
        if (start) begin
            done_d  = cfg_bad;
            bad_d   = cfg_bad;
            pass_d  = 1'b0;
            fail_d  = 8'd0;
            busy_d  = ~cfg_bad;
            v_d     = 3'd0;
            state_d = cfg_bad ? IDLE : DRIVE;
        end
        case (state_q)
            DRIVE: begin
                stim_d  = (3*NCH)'(v_q) << (3*chan_q);
                cnt_d   = settle_eff;
                state_d = SETTLE;
            end
            SETTLE: begin
                cnt_d   = cnt_q - 8'd1;
                state_d = (cnt_q <= 8'd1) ? SAMPLE : SETTLE;
            end
            SAMPLE: begin
                if (resp_i[chan_q] != exp_q[v_q]) fail_d[v_q] = 1'b1;
                v_d     = (v_q == last_v) ? v_q : v_q + 3'd1;
                state_d = (v_q == last_v) ? FINISH : DRIVE;
            end
            FINISH: begin
                stim_d  = '0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                pass_d  = (fail_q == 8'd0);
                run_d   = run_q + 16'd1;
                state_d = IDLE;
            end
            default: ;
        endcase
    end
    // state and register bank
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q  <= IDLE;
            v_q      <= '0;
            cnt_q    <= '0;
            stim_q   <= '0;
            chan_q   <= '0;
            nin_q    <= '0;
            exp_q    <= '0;
            settle_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            bad_q    <= 1'b0;
            fail_q   <= '0;
            run_q    <= '0;
            ack_q    <= 1'b0;
            dat_q    <= '0;
        end else begin
            state_q  <= state_d;
            v_q      <= v_d;
            cnt_q    <= cnt_d;
            stim_q   <= stim_d;
            chan_q   <= chan_d;
            nin_q    <= nin_d;
            exp_q    <= exp_d;
            settle_q <= settle_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            bad_q    <= bad_d;
            fail_q   <= fail_d;
            run_q    <= run_d;
            ack_q    <= ack_d;
            dat_q    <= dat_d;
        end
    end
endmodule

// File: tb/tb_cell_stim_checker.sv
// tb_cell_stim_checker: table-driven sweeps plus busy-write and mid-run reset sequences
module tb_cell_stim_checker;
    localparam int NCH = 11;
    localparam logic [31:0] BASE = 32'h3000_0000;
    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [31:0]       adr = '0, dat = '0;
    logic              ack, done;
    logic [31:0]       dat_o;
    logic [3*NCH-1:0]  stim;
    logic [NCH-1:0]    resp;
    logic [32:0]       seen;
    int                model = 0;
    int                n_chk = 0, n_fail = 0;

    cell_stim_checker dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
        .wbs_sel_i(4'hF), .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
        .stim_o(stim), .resp_i(resp), .done_o(done)
    );

    always #5 clk = ~clk;

    // cell models: 0 AND2, 1 AOI21 with OR leg on A (table 0x15), 2 AOI21 with OR leg on C (table 0x07), 3 stuck-1, 4 INV
    function automatic logic cell_y(int m, logic [2:0] x);
        case (m)
            0: return x[0] & x[1];
            1: return ~(x[0] | (x[1] & x[2]));
            2: return ~((x[0] & x[1]) | x[2]);
            3: return 1'b1;
            default: return ~x[0];
        endcase
    endfunction

    always_comb begin
        resp = '0;
        for (int c = 0; c < NCH; c++) resp[c] = cell_y(model, stim[3*c +: 3]);
    end

    always @(negedge clk) seen <= seen | {1'b0, stim};

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
        n_chk++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, expv);
        end
    endtask

    task automatic wb(input logic w, input logic [3:0] a, input logic [31:0] d, output logic [31:0] q);
        logic got;
        got = 1'b0;
        q = '0;
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = w; adr = BASE | {28'd0, a}; dat = d;
        for (int i = 0; i < 4 && !got; i++) begin
            @(negedge clk);
            if (ack) begin
                got = 1'b1;
                q = dat_o;
            end
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        chk("ack", {63'd0, got}, 64'd1);
    endtask

    task automatic wait_done(output int cnt);
        cnt = 0;
        while (!done && cnt < 2000) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    function automatic logic [31:0] ctrl(logic [3:0] ch, logic [1:0] nn, logic [7:0] e);
        return {8'd0, e, 6'd0, nn, ch, 4'd1};
    endfunction

    typedef struct {
        logic [3:0]  chan;
        logic [1:0]  nin;
        logic [7:0]  expv;
        logic [7:0]  settle;
        int          model;
        logic [31:0] status;
        int          busy;
        logic [32:0] stim;
    } vec_t;

    vec_t tbl[9];

    initial begin
        logic [31:0] q;
        int cnt, runs;
        tbl[0] = '{4'd0,  2'd1, 8'h08, 8'd2, 0, 32'h0006, 17, 33'h3};
        tbl[1] = '{4'd2,  2'd2, 8'h15, 8'd1, 1, 32'h0006, 25, 33'h1C0};
        tbl[2] = '{4'd2,  2'd2, 8'h15, 8'd1, 3, 32'hEA02, 25, 33'h1C0};
        tbl[3] = '{4'd5,  2'd2, 8'h07, 8'd3, 2, 32'h0006, 41, 33'h38000};
        tbl[4] = '{4'd4,  2'd0, 8'h01, 8'd0, 4, 32'h0006, 7,  33'h1000};
        tbl[5] = '{4'd11, 2'd1, 8'h08, 8'd2, 0, 32'h000A, 0,  33'h0};
        tbl[6] = '{4'd0,  2'd3, 8'h08, 8'd2, 0, 32'h000A, 0,  33'h0};
        tbl[7] = '{4'd10, 2'd0, 8'hFD, 8'd1, 4, 32'h0006, 7,  33'h4000_0000};
        tbl[8] = '{4'd3,  2'd1, 8'h0F, 8'd1, 0, 32'h0702, 13, 33'h600};
        seen = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ack", {63'd0, ack}, 64'd0);
        chk("rst_dat", {32'd0, dat_o}, 64'd0);
        chk("rst_stim", {31'd0, stim}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        wb(1'b0, 4'h4, 32'd0, q); chk("rst_status", {32'd0, q}, 64'd0);
        @(negedge clk);
        chk("dat_idle", {32'd0, dat_o}, 64'd0);
        wb(1'b0, 4'hC, 32'd0, q); chk("rst_runcnt", {32'd0, q}, 64'd0);
        stb = 1'b1; cyc = 1'b1; adr = BASE + 32'h10;
        cnt = 0;
        repeat (3) begin @(negedge clk); cnt += int'(ack); end
        adr = BASE; cyc = 1'b0;
        repeat (2) begin @(negedge clk); cnt += int'(ack); end
        stb = 1'b0;
        chk("nohit_ack", 64'(cnt), 64'd0);
        runs = 0;
        for (int i = 0; i < 9; i++) begin
            wb(1'b1, 4'h8, {24'd0, tbl[i].settle}, q);
            model = tbl[i].model;
            seen = '0;
            wb(1'b1, 4'h0, ctrl(tbl[i].chan, tbl[i].nin, tbl[i].expv), q);
            wait_done(cnt);
            if (tbl[i].busy != 0) runs++;
            chk($sformatf("busy_cycles[%0d]", i), 64'(cnt), 64'(tbl[i].busy));
            wb(1'b0, 4'h4, 32'd0, q); chk($sformatf("status[%0d]", i), {32'd0, q}, {32'd0, tbl[i].status});
            wb(1'b0, 4'hC, 32'd0, q); chk($sformatf("runcnt[%0d]", i), {32'd0, q}, 64'(runs));
            chk($sformatf("stim_seen[%0d]", i), {31'd0, seen}, {31'd0, tbl[i].stim});
            chk($sformatf("stim_end[%0d]", i), {31'd0, stim}, 64'd0);
        end
        model = 0;
        seen = '0;
        wb(1'b1, 4'h8, 32'd3, q);
        wb(1'b1, 4'h0, ctrl(4'd0, 2'd1, 8'h08), q);
        wb(1'b1, 4'h0, ctrl(4'd4, 2'd0, 8'h01), q);
        wb(1'b1, 4'h8, 32'd9, q);
        wait_done(cnt);
        runs++;
        chk("busy_wr_cycles", 64'(cnt + 4), 64'd21);
        wb(1'b0, 4'h4, 32'd0, q); chk("busy_wr_status", {32'd0, q}, 64'h6);
        wb(1'b0, 4'h0, 32'd0, q); chk("busy_wr_ctrl", {32'd0, q}, 64'h0008_0100);
        wb(1'b0, 4'h8, 32'd0, q); chk("busy_wr_settle", {32'd0, q}, 64'd3);
        wb(1'b0, 4'hC, 32'd0, q); chk("busy_wr_runcnt", {32'd0, q}, 64'(runs));
        chk("busy_wr_seen", {31'd0, seen}, 64'h3);
        model = 1;
        wb(1'b1, 4'h8, 32'd5, q);
        wb(1'b1, 4'h0, ctrl(4'd2, 2'd2, 8'h15), q);
        repeat (8) @(negedge clk);
        chk("mid_stim", {31'd0, stim}, 64'h40);
        chk("mid_done", {63'd0, done}, 64'd0);
        rst_n = 1'b0;
        #1;
        chk("arst_stim", {31'd0, stim}, 64'd0);
        chk("arst_done", {63'd0, done}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wb(1'b0, 4'h4, 32'd0, q); chk("post_rst_status", {32'd0, q}, 64'd0);
        wb(1'b0, 4'h8, 32'd0, q); chk("post_rst_settle", {32'd0, q}, 64'd0);
        chk("post_rst_stim", {31'd0, stim}, 64'd0);
        model = 0;
        wb(1'b1, 4'h8, 32'd2, q);
        wb(1'b1, 4'h0, ctrl(4'd0, 2'd1, 8'h08), q);
        wait_done(cnt);
        chk("fresh_busy", 64'(cnt), 64'd17);
        wb(1'b0, 4'h4, 32'd0, q); chk("fresh_status", {32'd0, q}, 64'h6);
        wb(1'b0, 4'hC, 32'd0, q); chk("fresh_runcnt", {32'd0, q}, 64'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
